// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit for a word: even parity yields XOR of the data, odd inverts it.
  function automatic logic parity_of(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_core_bit_timer.sv
// Per-bit cycle counter: counts 0..P-1 against the latched prescale and
// flags the last cycle of each bit. A prescale of 0 behaves as 1.
module tx_bit_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       run,
  input  logic [5:0] prescale,
  output logic       bit_done
);

  logic [5:0] edge_cnt;
  logic [5:0] last_cnt;

  assign last_cnt = (prescale == 6'd0) ? 6'd0 : prescale - 6'd1;
  assign bit_done = run && (edge_cnt == last_cnt);

  // Count cycles within a bit; restart and idle both pin the counter at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= 6'd0;
    end else if (restart || !run || bit_done) begin
      edge_cnt <= 6'd0;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, data LSB first, optional parity, one stop bit.
// A new word may be accepted in IDLE or in the last stop cycle, which gives
// gap-free back-to-back frames.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift_data;
  logic [IDX_W-1:0]      bit_idx;
  logic                  par_en_lat;
  logic                  par_bit;
  logic [5:0]            prescale_lat;
  logic                  bit_done;
  logic                  accept;
  logic                  run;

  assign run    = (state != IDLE);
  assign accept = data_valid && ((state == IDLE) || ((state == STOP) && bit_done));

  tx_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (accept),
    .run      (run),
    .prescale (prescale_lat),
    .bit_done (bit_done)
  );

  // Frame FSM with registered line and busy outputs; the parity bit is
  // computed once at acceptance so the shift register can consume the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shift_data   <= '0;
      bit_idx      <= '0;
      par_en_lat   <= 1'b0;
      par_bit      <= 1'b0;
      prescale_lat <= 6'd0;
      tx_out       <= STOP_BIT;
      busy         <= 1'b0;
    end else begin
      if (accept) begin
        shift_data   <= p_data;
        par_en_lat   <= par_en;
        par_bit      <= parity_of(^p_data, par_typ);
        prescale_lat <= prescale;
      end
      case (state)
        IDLE: begin
          tx_out <= STOP_BIT;
          busy   <= 1'b0;
          if (accept) begin
            state  <= START;
            tx_out <= START_BIT;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= shift_data[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_lat) begin
                state  <= PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= STOP;
                tx_out <= STOP_BIT;
              end
            end else begin
              bit_idx    <= bit_idx + IDX_W'(1);
              shift_data <= shift_data >> 1;
              tx_out     <= shift_data[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            tx_out <= STOP_BIT;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (accept) begin
              state  <= START;
              tx_out <= START_BIT;
            end else begin
              state  <= IDLE;
              tx_out <= STOP_BIT;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= STOP_BIT;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter that serializes one parallel data word per frame onto a single line. Each bit is held for `prescale` clock cycles. It is the transmit-side counterpart of the UART_RX datapath: it uses the same `prescale` meaning, the same `par_en`/`par_typ` conventions and the same frame format. It sits between the system-side data source (valid/busy handshake) and the serial pin.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk` input, 1 bit: clock. All logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `p_data` input, `DATA_WIDTH` bits: word to transmit. Sampled only on acceptance.
- `data_valid` input, 1 bit: request to send `p_data`.
- `par_en` input, 1 bit: 1 inserts a parity bit after the data bits.
- `par_typ` input, 1 bit: 0 selects even parity, 1 selects odd parity.
- `prescale` input, 6 bits: clock cycles per bit. A value of 0 is treated as 1.
- `tx_out` output, 1 bit: serial line. Idles high. Registered.
- `busy` output, 1 bit: high while a frame is in flight. Registered.

## Operation
- Frame layout: start bit (0), then `p_data` LSB first, then an optional parity bit, then one stop bit (1).
  - 10 bits without parity, 11 bits with parity, for `DATA_WIDTH`=8.
- Acceptance: a cycle where `data_valid`=1 and the FSM is in IDLE, or in the last cycle of STOP.
  - On acceptance, `p_data`, `par_en`, `par_typ` and `prescale` are latched.
  - Input changes mid-frame have no effect.
- `data_valid` in any other cycle is ignored. The word is not queued.
- Parity bit = XOR-reduce(latched data) XOR `par_typ`.
- FSM states and transitions:
  - IDLE: `tx_out`=1, `busy`=0. Moves to START on acceptance.
  - START: `tx_out`=0 for P cycles. Then moves to DATA.
  - DATA: `tx_out`=data[i] for P cycles per bit, i = 0 .. `DATA_WIDTH`-1. After the last bit, moves to PARITY if parity is latched enabled, otherwise to STOP.
  - PARITY: `tx_out`=parity bit for P cycles. Then moves to STOP.
  - STOP: `tx_out`=1 for P cycles. Then moves to START if acceptance occurred in the last stop cycle, otherwise to IDLE.
- Counters:
  - `edge_cnt` counts 0..P-1 within a bit. A bit ends when `edge_cnt`==P-1, and `edge_cnt` then wraps to 0.
  - `bit_idx` counts data bits, width ceil(log2(`DATA_WIDTH`)). It is cleared on entry to DATA.
- Reset, asynchronous at any time including mid-frame: FSM=IDLE, `tx_out`=1, `busy`=0, all counters 0, latched data 0. No partial frame resumes after reset release.

## Timing
- Acceptance at edge N: `tx_out` falls to 0 and `busy` rises at edge N+1, both in the same cycle.
- Each bit occupies exactly P consecutive cycles, with no jitter.
- Frame duration = P × (`DATA_WIDTH`+2+`par_en`) cycles, measured from the start-bit edge to the end of the stop bit.
- End of frame with no new request: `busy` falls and the FSM enters IDLE at the edge after the last stop cycle.
- Back-to-back frames: the next start bit begins immediately after the last stop cycle. `busy` stays high, with no idle gap.
- P=1: one cycle per bit. Back-to-back behaviour is unchanged.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity type constants `PAR_EVEN`=0, `PAR_ODD`=1.
  - Start/stop bit level constants.
  - Shared with UART_RX.
- One sub-module, `tx_bit_timer`: holds `edge_cnt` against the latched prescale and outputs a `bit_done` pulse.
  - It is restarted on acceptance.
  - FSM, shift/index and parity logic stay in `uart_tx_core`.

## Test plan
- Reset: hold `rst`=0 with `data_valid`=1. Required: `tx_out`=1 and `busy`=0 throughout. After release, the first accept occurs only when `data_valid` is sampled.
- `p_data`=0xA5, `par_en`=0, P=8. Required: 80-cycle frame with bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles wide. `busy` is high for exactly 80 cycles.
- `p_data`=0xA5, `par_en`=1, `par_typ`=0, P=16. Required: parity bit 0, an 11-bit frame, 176 cycles. Repeat with `par_typ`=1: parity bit 1.
- `p_data`=0x01, `par_en`=1, `par_typ`=1, P=8. Required: parity bit 0. Change `p_data` and `prescale` mid-frame: required, no effect on the frame in flight.
- Back-to-back: 0x3C then 0xC3, with `data_valid` high in the last stop cycle, P=8. Required: the second start bit directly follows the first stop bit and `busy` never drops. A `data_valid` pulse mid-frame is ignored.
- Reset mid-DATA at bit 4: required, `tx_out`=1 and `busy`=0 immediately (asynchronous). A new frame after release is transmitted correctly.
